// File: rtl/pipelined_barrel_shifter.sv
// Pipelined ARM-style barrel shifter (LSL/LSR/ASR/ROR/RRX) with valid/ready handshake and tag passthrough.
// Optional zero/negative result flags are enabled by defining BARREL_SHIFTER_FLAGS_EN.
module pipelined_barrel_shifter #(
    parameter int WIDTH   = 32,
    parameter int AMT_W   = 8,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [2:0]       in_mode,
    input  logic             in_carry,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
`ifdef BARREL_SHIFTER_FLAGS_EN
    output logic             out_zero,
    output logic             out_neg,
`endif
    output logic [TAG_W-1:0] out_tag
);
    localparam int LOG = $clog2(WIDTH);

    localparam logic [1:0] K_LSL = 2'd0;
    localparam logic [1:0] K_LSR = 2'd1;
    localparam logic [1:0] K_ASR = 2'd2;

    // Applies mux levels lo..hi-1; level i moves the word by 2**i when amt[i] is set.
    function automatic logic [WIDTH-1:0] shift_levels(input logic [WIDTH-1:0] d,
                                                      input logic [LOG-1:0]   amt,
                                                      input logic [1:0]       kind,
                                                      input int               lo,
                                                      input int               hi);
        logic [WIDTH-1:0]        r;
        logic signed [WIDTH-1:0] sr;
        r = d;
        for (int i = 0; i < LOG; i++) begin
            if (i >= lo && i < hi && amt[i]) begin
                case (kind)
                    K_LSL:   r = r << (1 << i);
                    K_LSR:   r = r >> (1 << i);
                    K_ASR: begin
                        sr = r;
                        sr = sr >>> (1 << i);
                        r  = sr;
                    end
                    default: r = (r >> (1 << i)) | (r << (WIDTH - (1 << i)));
                endcase
            end
        end
        return r;
    endfunction

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    logic [31:0]      n_ext;
    logic             n_zero, n_eq_w, n_gt_w, n_lt_w;
    logic [LOG-1:0]   n_mod, idx_dn, idx_up;
    logic [WIDTH-1:0] dec_data;
    logic [LOG-1:0]   dec_amt;
    logic [1:0]       dec_kind;
    logic             dec_carry;

    assign n_ext  = 32'(in_amt);
    assign n_zero = (n_ext == 32'd0);
    assign n_eq_w = (n_ext == 32'(WIDTH));
    assign n_gt_w = (n_ext > 32'(WIDTH));
    assign n_lt_w = !n_eq_w && !n_gt_w;
    assign n_mod  = in_amt[LOG-1:0];
    assign idx_dn = n_mod - 1'b1;
    assign idx_up = ~n_mod + 1'b1;

    // Out-of-range shifts become a constant word with zero residual amount; carry is final here.
    always_comb begin
        dec_data  = in_data;
        dec_amt   = '0;
        dec_kind  = in_mode[1:0];
        dec_carry = in_carry;
        case (in_mode)
            3'd0: if (!n_zero) begin
                if (n_lt_w) begin
                    dec_amt   = n_mod;
                    dec_carry = in_data[idx_up];
                end else begin
                    dec_data  = '0;
                    dec_carry = n_eq_w ? in_data[0] : 1'b0;
                end
            end
            3'd1: if (!n_zero) begin
                if (n_lt_w) begin
                    dec_amt   = n_mod;
                    dec_carry = in_data[idx_dn];
                end else begin
                    dec_data  = '0;
                    dec_carry = n_eq_w ? in_data[WIDTH-1] : 1'b0;
                end
            end
            3'd2: if (!n_zero) begin
                if (n_lt_w) begin
                    dec_amt   = n_mod;
                    dec_carry = in_data[idx_dn];
                end else begin
                    dec_data  = {WIDTH{in_data[WIDTH-1]}};
                    dec_carry = in_data[WIDTH-1];
                end
            end
            3'd3: if (!n_zero) begin
                dec_amt   = n_mod;
                dec_carry = in_data[idx_dn];
            end
            3'd4: begin
                dec_data  = {in_carry, in_data[WIDTH-1:1]};
                dec_carry = in_data[0];
            end
            default: ;
        endcase
    end

    for (genvar s = 0; s < LATENCY; s++) begin : g_stg
        localparam int LO = (s * LOG) / LATENCY;
        localparam int HI = ((s + 1) * LOG) / LATENCY;

        logic [WIDTH-1:0] src_data, data_d, data_q;
        logic [LOG-1:0]   src_amt;
        logic [1:0]       src_kind;
        logic             src_carry, src_vld, carry_q, vld_q;
        logic [TAG_W-1:0] src_tag, tag_q;

        if (s == 0) begin : g_in
            assign src_data  = dec_data;
            assign src_amt   = dec_amt;
            assign src_kind  = dec_kind;
            assign src_carry = dec_carry;
            assign src_vld   = in_valid;
            assign src_tag   = in_tag;
        end else begin : g_chain
            assign src_data  = g_stg[s-1].data_q;
            assign src_amt   = g_stg[s-1].g_fwd.amt_q;
            assign src_kind  = g_stg[s-1].g_fwd.kind_q;
            assign src_carry = g_stg[s-1].carry_q;
            assign src_vld   = g_stg[s-1].vld_q;
            assign src_tag   = g_stg[s-1].tag_q;
        end

        assign data_d = shift_levels(src_data, src_amt, src_kind, LO, HI);

        // Stage s register boundary: every stage moves together on advance.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q  <= '0;
                carry_q <= 1'b0;
                vld_q   <= 1'b0;
                tag_q   <= '0;
            end else if (advance) begin
                data_q  <= data_d;
                carry_q <= src_carry;
                vld_q   <= src_vld;
                tag_q   <= src_tag;
            end
        end

        if (s < LATENCY - 1) begin : g_fwd
            logic [LOG-1:0] amt_q;
            logic [1:0]     kind_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    amt_q  <= '0;
                    kind_q <= '0;
                end else if (advance) begin
                    amt_q  <= src_amt;
                    kind_q <= src_kind;
                end
            end
        end
    end

    assign out_valid = g_stg[LATENCY-1].vld_q;
    assign out_data  = g_stg[LATENCY-1].data_q;
    assign out_carry = g_stg[LATENCY-1].carry_q;
    assign out_tag   = g_stg[LATENCY-1].tag_q;

`ifdef BARREL_SHIFTER_FLAGS_EN
    logic zero_q, neg_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (advance) begin
            zero_q <= (g_stg[LATENCY-1].data_d == '0);
            neg_q  <= g_stg[LATENCY-1].data_d[WIDTH-1];
        end
    end
    assign out_zero = zero_q;
    assign out_neg  = neg_q;
`else
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter: directed boundary cases, throughput,
// backpressure, mid-flight reset and randomized traffic against a rule-level reference model.
module tb_pipelined_barrel_shifter;
    localparam int W   = 32;
    localparam int LAT = 2;
    localparam int TW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [7:0]    in_amt = '0;
    logic [2:0]    in_mode = '0;
    logic          in_carry = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic          out_carry;
    logic [TW-1:0] out_tag;
`ifdef BARREL_SHIFTER_FLAGS_EN
    logic          out_zero;
    logic          out_neg;
`endif

    pipelined_barrel_shifter #(.WIDTH(W), .AMT_W(8), .LATENCY(LAT), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt),
        .in_mode(in_mode), .in_carry(in_carry), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_carry(out_carry),
`ifdef BARREL_SHIFTER_FLAGS_EN
        .out_zero(out_zero), .out_neg(out_neg),
`endif
        .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  data;
        logic          carry;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            bp_mode = 0;
    logic [TW-1:0] tag_ctr = '0;
    bit            tp_active = 0;
    bit            tp_arm = 0;
    int            tp_start = 0;
    int            tp_prev = 0;
    int            tp_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: straight from the shift rules, returns {carry, data}.
    function automatic logic [W:0] ref_shift(input logic [W-1:0] d, input int n,
                                             input int mode, input logic cin);
        logic [W-1:0] r;
        logic         c;
        int           k;
        r = d;
        c = cin;
        case (mode)
            0: if (n > 0) begin
                if (n < W)       begin r = d << n; c = d[W-n]; end
                else if (n == W) begin r = '0; c = d[0]; end
                else             begin r = '0; c = 1'b0; end
            end
            1: if (n > 0) begin
                if (n < W)       begin r = d >> n; c = d[n-1]; end
                else if (n == W) begin r = '0; c = d[W-1]; end
                else             begin r = '0; c = 1'b0; end
            end
            2: if (n > 0) begin
                if (n < W) begin
                    repeat (n) r = {r[W-1], r[W-1:1]};
                    c = d[n-1];
                end else begin
                    r = {W{d[W-1]}};
                    c = d[W-1];
                end
            end
            3: if (n > 0) begin
                k = n % W;
                repeat (k) r = {r[0], r[W-1:1]};
                c = (k == 0) ? d[W-1] : r[W-1];
            end
            4: begin
                r = {cin, d[W-1:1]};
                c = d[0];
            end
            default: ;
        endcase
        return {c, r};
    endfunction

    // Called at posedge+#1; returns at the posedge+#1 after acceptance.
    task automatic send(input logic [W-1:0] d, input int a, input int m, input logic c,
                        input logic [W-1:0] ed, input logic ec);
        int   guard;
        exp_t e;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = 8'(a);
        in_mode  = 3'(m);
        in_carry = c;
        in_tag   = tag_ctr;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stuck at 0 for tag %0d", tag_ctr);
        end else begin
            e.data  = ed;
            e.carry = ec;
            e.tag   = tag_ctr;
            sb.push_back(e);
            if (tp_arm) begin
                tp_start = cyc;
                tp_arm   = 0;
            end
        end
        tag_ctr++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [W-1:0] d, input int a, input int m, input logic c);
        logic [W:0] r;
        r = ref_shift(d, a, m, c);
        send(d, a, m, c, r[W-1:0], r[W]);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 300) begin
            @(posedge clk);
            g++;
        end
        #1;
        chk("drain_queue_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compares every consumed result against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: tag %0d data 0x%0h with empty scoreboard",
                             out_tag, out_data);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", 64'(out_data), 64'(e.data));
                    chk("out_carry", 64'(out_carry), 64'(e.carry));
                    chk("out_tag", 64'(out_tag), 64'(e.tag));
`ifdef BARREL_SHIFTER_FLAGS_EN
                    chk("out_zero", 64'(out_zero), 64'(e.data == '0));
                    chk("out_neg", 64'(out_neg), 64'(e.data[W-1]));
`endif
                    if (tp_active) begin
                        if (tp_cnt == 0) chk("first_latency", 64'(cyc - tp_start), 64'(LAT));
                        else             chk("back_to_back", 64'(cyc - tp_prev), 64'd1);
                        tp_prev = cyc;
                        tp_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0]  snap_d;
        logic          snap_c;
        logic [TW-1:0] snap_t;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        chk("reset_out_carry", 64'(out_carry), 64'd0);
        chk("reset_out_tag", 64'(out_tag), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed boundary cases with hand-derived results
        send(32'h8000_0001, 32, 0, 1'b0, 32'h0000_0000, 1'b1);
        send(32'h8000_0001, 33, 1, 1'b1, 32'h0000_0000, 1'b0);
        send(32'h8000_0001, 40, 2, 1'b0, 32'hFFFF_FFFF, 1'b1);
        send(32'h8000_0001, 1,  2, 1'b0, 32'hC000_0000, 1'b1);
        send(32'h0000_0008, 3,  3, 1'b1, 32'h0000_0001, 1'b0);
        send(32'h0000_0008, 35, 3, 1'b1, 32'h0000_0001, 1'b0);
        send(32'h0000_0008, 32, 3, 1'b1, 32'h0000_0008, 1'b0);
        send(32'h0000_0008, 7,  4, 1'b1, 32'h8000_0004, 1'b0);
        send(32'h1234_5678, 0,  1, 1'b1, 32'h1234_5678, 1'b1);
        send(32'h1234_5678, 9,  6, 1'b0, 32'h1234_5678, 1'b0);

        for (int m = 0; m < 3; m++) begin
            send_m(32'h8000_0001, 1,  m, 1'(m));
            send_m(32'h8000_0001, 31, m, 1'(m));
            send_m(32'h8000_0001, 32, m, 1'(m));
            send_m(32'h8000_0001, 33, m, 1'(m));
        end
        drain();

        // Throughput and latency: 8 back-to-back ops, tags 0..7
        tag_ctr   = '0;
        tp_cnt    = 0;
        tp_arm    = 1;
        tp_active = 1;
        for (int i = 0; i < 8; i++) send_m($urandom, $urandom_range(0, 40), $urandom_range(0, 4), 1'($urandom));
        drain();
        tp_active = 0;
        chk("throughput_count", 64'(tp_cnt), 64'd8);

        // Backpressure: stall a valid result for 5 cycles
        bp_mode = 2;
        @(posedge clk);
        #1;
        send_m(32'hDEAD_BEEF, 4, 1, 1'b0);
        send_m(32'hCAFE_F00D, 12, 3, 1'b1);
        @(negedge clk);
        snap_d = out_data;
        snap_c = out_carry;
        snap_t = out_tag;
        for (int i = 0; i < 5; i++) begin
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_data_stable", 64'(out_data), 64'(snap_d));
            chk("stall_carry_stable", 64'(out_carry), 64'(snap_c));
            chk("stall_tag_stable", 64'(out_tag), 64'(snap_t));
            @(negedge clk);
        end
        bp_mode = 0;
        drain();

        // Reset with two ops in flight
        bp_mode = 2;
        @(posedge clk);
        #1;
        send_m(32'h0F0F_0F0F, 5, 0, 1'b0);
        send_m(32'hF0F0_F0F0, 6, 2, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_out_data", 64'(out_data), 64'd0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postreset_in_ready", 64'(in_ready), 64'd1);
        bp_mode = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("postreset_no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // Randomized traffic with random backpressure
        bp_mode = 1;
        for (int i = 0; i < 300; i++) begin
            int a;
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 40));
            send_m($urandom, a, $urandom_range(0, 7), 1'($urandom));
        end
        bp_mode = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
